// File: rtl/sha2_pad_pkg.sv
// sha2_pad_pkg: shared types and constants for the SHA-256 message padder.
//   sha_word_t  - 32-bit message/padding word
//   sha_fifo_t  - input stream word {data[31:0], mask[3:0]}, big-endian,
//                 byte0 = data[31:24], mask[3] qualifies byte0
//   BlockSize   - SHA-256 block size in bits
//   LenOffset   - bit offset in a block where the 64-bit length field starts
//   tail_word() - builds the word that closes a message mid-word
package sha2_pad_pkg;

  localparam int BlockSize = 512;
  localparam int LenOffset = 448;

  typedef logic [31:0] sha_word_t;

  typedef struct packed {
    sha_word_t  data;
    logic [3:0] mask;
  } sha_fifo_t;

  // Keep the first nbytes message bytes, append 0x80, zero the rest.
  function automatic sha_word_t tail_word(sha_word_t d, logic [1:0] nbytes);
    sha_word_t w;
    case (nbytes)
      2'd1:    w = {d[31:24], 8'h80, 16'h0000};
      2'd2:    w = {d[31:16], 8'h80, 8'h00};
      2'd3:    w = {d[31:8], 8'h80};
      default: w = 32'h8000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha2_pad_if.sv
// sha2_pad_if: input message stream and padded output stream of the padder.
//   in_valid/in_data/in_ready     - message words into the padder
//   out_valid/out_data/out_last/out_ready - padded words to the compressor
// Handshake: a word transfers on a rising clock edge where valid && ready.
// A producer holds valid and data steady until that transfer; ready may be
// asserted or withdrawn freely and never depends on a transfer completing.
// slave modport is the padder's view, master is the surrounding system's.
interface sha2_pad_if;
  import sha2_pad_pkg::*;

  logic      in_valid;
  sha_fifo_t in_data;
  logic      in_ready;
  logic      out_valid;
  sha_word_t out_data;
  logic      out_last;
  logic      out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sha2_pad.sv
// sha2_pad: SHA-256 message padder. Forwards 32-bit message words and
// appends 0x80, zero words and the 64-bit bit length so the output is a
// whole number of 512-bit blocks.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   hash_start      - pulse: restart (clears counter and process flag)
//   hash_process    - pulse: all message words are committed
//   message_length  - message length in bits, bits [2:0] ignored
//   bus             - sha2_pad_if.slave (input and output streams)
//   tx_count        - bits emitted since hash_start
//   pad_done        - one-cycle pulse after the final word transfers
//   idle            - in idle state with no hash_start pending
//   state_dbg       - FSM state: 0 Idle, 1 Msg, 2 Pad80, 3 Pad00,
//                     4 LenHi, 5 LenLo, 6 Done
module sha2_pad
  import sha2_pad_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hash_start,
  input  logic        hash_process,
  input  logic [63:0] message_length,
  sha2_pad_if.slave   bus,
  output logic [63:0] tx_count,
  output logic        pad_done,
  output logic        idle,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMsg   = 3'd1,
    StPad80 = 3'd2,
    StPad00 = 3'd3,
    StLenHi = 3'd4,
    StLenLo = 3'd5,
    StDone  = 3'd6
  } state_e;

  state_e      state_q;
  logic        process_q;
  logic [63:0] len_bits;
  logic [63:0] remaining;
  logic        fwd;
  logic [1:0]  tail_bytes;
  logic        at_len;
  logic        out_hs;
  logic        unused_mask;

  // Mask bytes carry no information: length alone decides where data ends.
  assign unused_mask = ^bus.in_data.mask;

  assign len_bits   = message_length & ~64'h7;
  assign remaining  = len_bits - tx_count;
  assign fwd        = remaining >= 64'd32;
  // Below 32 the remainder is a multiple of 8, i.e. 0..3 whole bytes.
  assign tail_bytes = remaining[4:3];
  assign at_len     = tx_count[8:0] == 9'(LenOffset);
  assign out_hs     = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    case (state_q)
      StMsg: begin
        if (fwd) begin
          // Zero-latency pass-through of full message words.
          bus.out_valid = bus.in_valid;
          bus.out_data  = bus.in_data.data;
          bus.in_ready  = bus.out_ready;
        end else if (process_q && tail_bytes != 2'd0) begin
          bus.out_valid = bus.in_valid;
          bus.out_data  = tail_word(bus.in_data.data, tail_bytes);
          bus.in_ready  = bus.out_ready;
        end
      end
      StPad80: begin
        bus.out_valid = 1'b1;
        bus.out_data  = 32'h8000_0000;
      end
      StPad00: bus.out_valid = !at_len;
      StLenHi: begin
        bus.out_valid = 1'b1;
        bus.out_data  = len_bits[63:32];
      end
      StLenLo: begin
        bus.out_valid = 1'b1;
        bus.out_data  = len_bits[31:0];
        bus.out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tx_count  <= '0;
      process_q <= 1'b0;
    end else if (hash_start) begin
      // Restart wins over everything, including a same-cycle hash_process
      // and any word transferring this cycle.
      state_q   <= StMsg;
      tx_count  <= '0;
      process_q <= 1'b0;
    end else begin
      if (out_hs) tx_count <= tx_count + 64'd32;
      if (state_q == StDone)  process_q <= 1'b0;
      else if (hash_process)  process_q <= 1'b1;
      case (state_q)
        StMsg: begin
          if (!fwd && process_q) begin
            if (tail_bytes == 2'd0) state_q <= StPad80;
            else if (out_hs)        state_q <= StPad00;
          end
        end
        StPad80: if (out_hs) state_q <= StPad00;
        // Zero words run until the counter reaches the length slot; when the
        // 0x80 lands past it this naturally spills into the next block.
        StPad00: if (at_len) state_q <= StLenHi;
        StLenHi: if (out_hs) state_q <= StLenLo;
        StLenLo: if (out_hs) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pad_done  = state_q == StDone;
  assign idle      = (state_q == StIdle) && !hash_start;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sha2_pad.sv
// tb_sha2_pad: self-checking bench for sha2_pad. Expected output words come
// from a byte-level padding model (message bytes, 0x80, zeros to 56 mod 64,
// 64-bit big-endian bit length), compared on every output transfer.
module tb_sha2_pad;
  import sha2_pad_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hash_start = 1'b0;
  logic        hash_process = 1'b0;
  logic [63:0] message_length = '0;
  logic [63:0] tx_count;
  logic        pad_done;
  logic        idle;
  logic [2:0]  state_dbg;

  sha2_pad_if bus();

  always #5 clk = ~clk;

  sha2_pad dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .hash_start     (hash_start),
    .hash_process   (hash_process),
    .message_length (message_length),
    .bus            (bus),
    .tx_count       (tx_count),
    .pad_done       (pad_done),
    .idle           (idle),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  int          pd_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  msg_bytes[$];
  bit          mon_en = 0;
  bit          rand_ready = 0;
  bit          no_consume = 0;
  bit          pd_due = 0;
  bit          prev_stall = 0;
  bit          prev_start = 0;
  logic [31:0] prev_data = '0;
  logic [31:0] mon_e;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Downstream ready: always on, or a 50% random toggle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pad_done", 64'(pad_done), 64'(pd_due));
      pd_due = 0;
      if (pad_done) pd_count++;
      if (no_consume) chk("in_ready_beyond_len", 64'(bus.in_ready), 64'd0);
      if (prev_stall && !prev_start) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(prev_data));
      end
      if (bus.out_valid && bus.out_ready && !hash_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h want none at %0t", bus.out_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(mon_e));
          chk("out_last", 64'(bus.out_last), 64'(exp_q.size() == 0));
          got_q.push_back(bus.out_data);
          if (exp_q.size() == 0) pd_due = 1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !hash_start;
      prev_data  = bus.out_data;
      prev_start = hash_start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic feed_words();
    int nb, nw, t;
    logic [31:0] d;
    logic [3:0]  m;
    bit acc;
    nb = msg_bytes.size();
    nw = (nb + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      m = '0;
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < nb) begin
          d[31 - 8 * b -: 8] = msg_bytes[4 * w + b];
          m[3 - b] = 1'b1;
        end else begin
          d[31 - 8 * b -: 8] = 8'($urandom_range(0, 255));
        end
      end
      bus.in_data  = {d, m};
      bus.in_valid = 1'b1;
      t = 0;
      acc = 0;
      while (!acc && t < 1000) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      bus.in_valid = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL in_handshake_timeout: got none want word %0d", w);
        return;
      end
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_after(input int d);
    if (d < 0) return;
    repeat (d) begin
      @(posedge clk);
      #1;
    end
    hash_process = 1'b1;
    @(posedge clk);
    #1;
    hash_process = 1'b0;
  endtask

  // Sends msg_bytes; proc_delay < 0 withholds hash_process until 3 cycles
  // after the last word; abort_at > 0 returns once that many words came out.
  task automatic send_msg(input int proc_delay, input bit do_start, input int abort_at);
    logic [7:0]  pb[$];
    logic [63:0] lbits;
    int nwords, t, pd0;
    got_q.delete();
    pb = msg_bytes;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    lbits = 64'(msg_bytes.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pb.push_back(lbits[8 * k +: 8]);
    nwords = pb.size() / 4;
    for (int w = 0; w < nwords; w++)
      exp_q.push_back({pb[4 * w], pb[4 * w + 1], pb[4 * w + 2], pb[4 * w + 3]});
    message_length = lbits | 64'($urandom_range(0, 7));
    pd0 = pd_count;
    if (do_start) begin
      hash_start = 1'b1;
      @(posedge clk);
      #1;
      hash_start = 1'b0;
    end
    if (proc_delay >= 0) begin
      fork
        feed_words();
        pulse_after(proc_delay);
      join
    end else begin
      feed_words();
      no_consume   = 1;
      bus.in_valid = 1'b1;
      bus.in_data  = {32'($urandom), 4'hF};
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("wait_in_ready", 64'(bus.in_ready), 64'd0);
        chk("wait_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
      end
      hash_process = 1'b1;
      @(posedge clk);
      #1;
      hash_process = 1'b0;
    end
    if (abort_at > 0) begin
      t = 0;
      while (got_q.size() < abort_at && t < 2000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (got_q.size() < abort_at) begin
        checks++;
        errors++;
        $display("FAIL abort_wait_timeout: got %0d want %0d words", got_q.size(), abort_at);
      end
      return;
    end
    t = 0;
    while (pd_count == pd0 && t < 4000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (pd_count == pd0) begin
      checks++;
      errors++;
      $display("FAIL pad_done_timeout: got none want pulse");
    end
    bus.in_valid = 1'b0;
    no_consume   = 0;
    chk("tx_count", tx_count, 64'(nwords) * 64'd32);
    chk("idle_after", 64'(idle), 64'd1);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_bytes(input int n);
    msg_bytes.delete();
    for (int i = 0; i < n; i++) msg_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_pad_done", 64'(pad_done), 64'd0);
    chk("rst_tx_count", tx_count, 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // "abc"
    msg_bytes.delete();
    msg_bytes.push_back(8'h61);
    msg_bytes.push_back(8'h62);
    msg_bytes.push_back(8'h63);
    send_msg(0, 1, 0);
    chk("abc_words", 64'(got_q.size()), 64'd16);
    chk("abc_first", 64'(got_q[0]), 64'h6162_6380);
    chk("abc_last", 64'(got_q[15]), 64'h0000_0018);

    // empty message
    msg_bytes.delete();
    send_msg(1, 1, 0);
    chk("empty_words", 64'(got_q.size()), 64'd16);
    chk("empty_first", 64'(got_q[0]), 64'h8000_0000);
    chk("empty_last", 64'(got_q[15]), 64'h0000_0000);

    // 448 bits: padding spills into a second block
    rand_bytes(56);
    send_msg(2, 1, 0);
    chk("l448_words", 64'(got_q.size()), 64'd32);
    chk("l448_pad80", 64'(got_q[14]), 64'h8000_0000);
    chk("l448_last", 64'(got_q[31]), 64'h0000_01C0);

    // 512 bits with random back-pressure
    rand_ready = 1;
    rand_bytes(64);
    send_msg(5, 1, 0);
    chk("l512_pad80", 64'(got_q[16]), 64'h8000_0000);
    chk("l512_last", 64'(got_q[31]), 64'h0000_0200);
    rand_ready = 0;

    // hash_process withheld after the last word
    rand_bytes(20);
    send_msg(-1, 1, 0);
    chk("late_proc_words", 64'(got_q.size()), 64'd16);

    // restart during zero padding, then a one-byte message
    rand_bytes(3);
    send_msg(0, 1, 4);
    hash_start = 1'b1;
    message_length = 64'd8;
    exp_q.delete();
    @(posedge clk);
    #1;
    hash_start = 1'b0;
    chk("abort_state", 64'(state_dbg), 64'd1);
    chk("abort_tx_count", tx_count, 64'd0);
    msg_bytes.delete();
    msg_bytes.push_back(8'hAB);
    send_msg(0, 0, 0);
    chk("ab_first", 64'(got_q[0]), 64'hAB80_0000);
    chk("ab_last", 64'(got_q[15]), 64'h0000_0008);

    // randomized messages
    for (int i = 0; i < 10; i++) begin
      rand_ready = 1'($urandom_range(0, 1));
      rand_bytes($urandom_range(0, 130));
      send_msg($urandom_range(0, 30), 1, 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
